// File: rtl/lat_tester_ctrl.sv
// Latency-tester controller: arms on a dark frame edge, flashes the white patch and
// times in microseconds how long the photodiode takes to see it.
module lat_tester_ctrl #(
  parameter int   PRESCALE    = 27,
  parameter int   TIMEOUT_US  = 50000,
  parameter int   ARM_FRAMES  = 8,
  parameter int   COOLDOWN_FR = 4,
  parameter logic SENSOR_POL  = 1'b1
) (
  input  logic        clk27,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  mode_sel,
  input  logic        vsync_n,
  input  logic        sensor,
  output logic        lt_active,
  output logic [1:0]  lt_mode,
  output logic [15:0] result_us,
  output logic        result_valid,
  output logic        timeout,
  output logic        busy
);

  localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FMAX = (ARM_FRAMES > COOLDOWN_FR) ? ARM_FRAMES : COOLDOWN_FR;
  localparam int FW   = $clog2(FMAX + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [15:0]   US_LIMIT = 16'(TIMEOUT_US);
  localparam logic [FW-1:0] ARM_END  = FW'(ARM_FRAMES);
  localparam logic [FW-1:0] COOL_END = FW'(COOLDOWN_FR);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, COOLDOWN} state_t;

  state_t        state, state_next;
  logic          sens_q1, sens_q2, vsync_n_d;
  logic          lit_s, vs_fall;
  logic [PW-1:0] presc, presc_next;
  logic [15:0]   us_cnt, us_next;
  logic [FW-1:0] frame_cnt, frame_next;
  logic          active_next, valid_next, tmo_next;
  logic [1:0]    mode_next;
  logic [15:0]   result_next;

  assign lit_s   = sens_q2 ~^ SENSOR_POL;
  assign vs_fall = vsync_n_d & ~vsync_n;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk27) begin
    if (!reset_n) begin
      state        <= IDLE;
      sens_q1      <= 1'b0;
      sens_q2      <= 1'b0;
      vsync_n_d    <= 1'b0;
      presc        <= '0;
      us_cnt       <= '0;
      frame_cnt    <= '0;
      lt_active    <= 1'b0;
      lt_mode      <= 2'd0;
      result_us    <= 16'd0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_next;
      sens_q1      <= sensor;
      sens_q2      <= sens_q1;
      vsync_n_d    <= vsync_n;
      presc        <= presc_next;
      us_cnt       <= us_next;
      frame_cnt    <= frame_next;
      lt_active    <= active_next;
      lt_mode      <= mode_next;
      result_us    <= result_next;
      result_valid <= valid_next;
      timeout      <= tmo_next;
    end
  end

  always_comb begin
    state_next  = state;
    presc_next  = presc;
    us_next     = us_cnt;
    frame_next  = frame_cnt;
    active_next = lt_active;
    mode_next   = lt_mode;
    result_next = result_us;
    valid_next  = result_valid;
    tmo_next    = timeout;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = ARM;
          mode_next  = mode_sel;
          valid_next = 1'b0;
          tmo_next   = 1'b0;
          frame_next = '0;
        end
      end

      ARM: begin
        if (vs_fall) begin
          if (!lit_s) begin
            state_next  = MEASURE;
            active_next = 1'b1;
            presc_next  = '0;
            us_next     = '0;
          end else if (frame_cnt + 1'b1 == ARM_END) begin
            state_next  = IDLE;
            frame_next  = frame_cnt + 1'b1;
            tmo_next    = 1'b1;
            result_next = 16'hFFFF;
          end else begin
            frame_next = frame_cnt + 1'b1;
          end
        end
      end

      MEASURE: begin
        // us counter saturates rather than wrapping; the timeout normally stops it first
        if (presc == PRE_LAST) begin
          presc_next = '0;
          if (us_cnt != 16'hFFFF) us_next = us_cnt + 1'b1;
        end else begin
          presc_next = presc + 1'b1;
        end

        if (lit_s) begin
          state_next  = COOLDOWN;
          result_next = us_cnt;
          valid_next  = 1'b1;
          active_next = 1'b0;
          frame_next  = '0;
        end else if (us_cnt == US_LIMIT) begin
          state_next  = COOLDOWN;
          tmo_next    = 1'b1;
          result_next = 16'hFFFF;
          active_next = 1'b0;
          frame_next  = '0;
        end
      end

      COOLDOWN: begin
        if (vs_fall) begin
          frame_next = frame_cnt + 1'b1;
          if (frame_cnt + 1'b1 == COOL_END) state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
